rf_access_ctrl: RTL and testbench

Register-file access sequencer: the initiator side of the 16×32 register file's read/write port. Accepts one instruction-level request (two source registers, one destination), drives the register-file read selects and samples PA/PB, hands operands to the execute stage, then writes the returned result through the file's decoder write port. It sits between instruction decode and the register file and is the only block that drives the file's SA, SB, DSEL, IN, Dec_EN and Mux_EN_Sel.

---
 rtl/rf_access_ctrl_pkg.sv | 23 ++
 rtl/rf_lat_timer.sv | 33 +++
 rtl/rf_access_ctrl.sv | 136 +++++++++++++
 tb/tb_rf_access_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_access_ctrl_pkg.sv
// rf_access_ctrl_pkg
// Shared definitions for the register-file access sequencer:
//   - FSM state encoding (state_e)
//   - default register data / index widths
//   - read-mux enable encodings driven on Mux_EN_Sel
package rf_access_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_OP_OUT   = 3'd2,
    S_WB_WAIT  = 3'd3,
    S_WB_WRITE = 3'd4,
    S_WB_HOLD  = 3'd5
  } state_e;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;

  localparam logic [1:0] MUX_EN_BOTH = 2'b11;
  localparam logic [1:0] MUX_EN_OFF  = 2'b00;

endpackage

// File: rtl/rf_lat_timer.sv
// rf_lat_timer
// Loadable 3-bit down-counter that times how long the read selects are held
// before the register-file read data is sampled.
// Ports:
//   CLK, CLR    clock, asynchronous active-low reset
//   load        load load_val (takes priority over en)
//   load_val    start count
//   en          decrement by one per cycle, saturating at zero
//   done        count has reached 1: the current cycle is the last hold cycle
module rf_lat_timer (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       en,
  output logic       done
);

  logic [2:0] count;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      count <= 3'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != 3'd0)) begin
      count <= count - 3'd1;
    end
  end

  assign done = (count == 3'd1);

endmodule

// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl
// Initiator side of the 16x32 register file's read/write port. Accepts one
// request (two sources, one destination), drives the read selects, samples
// PA/PB into operands for execute, then writes the returned result through
// the file's decoder write port. Requests are fully serialized, so a read
// following a write to the same register sees the new value without bypass.
// Ports:
//   CLK, CLR                        clock, asynchronous active-low reset
//   req_valid/req_ready, req_rn/rm/rd, req_we   request from decode
//   op_valid/op_ready, op_a/op_b, op_rd, op_we  operands to execute
//   res_valid/res_ready, res_data               writeback from execute
//   SA, SB, Mux_EN_Sel, PA, PB                  register-file read port
//   DSEL, IN, Dec_EN                            register-file write port
//   busy                                        sequencer not idle
module rf_access_ctrl
  import rf_access_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rn,
  input  logic [ADDR_W-1:0] req_rm,
  input  logic [ADDR_W-1:0] req_rd,
  input  logic              req_we,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [ADDR_W-1:0] op_rd,
  output logic              op_we,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [DATA_W-1:0] res_data,
  output logic [ADDR_W-1:0] SA,
  output logic [ADDR_W-1:0] SB,
  output logic [1:0]        Mux_EN_Sel,
  input  logic [DATA_W-1:0] PA,
  input  logic [DATA_W-1:0] PB,
  output logic [ADDR_W-1:0] DSEL,
  output logic [DATA_W-1:0] IN,
  output logic              Dec_EN,
  output logic              busy
);

  state_e state, state_nxt;
  logic   accept, op_fire, res_fire, tmr_done, capture;

  assign req_ready = (state == S_IDLE);
  assign res_ready = (state == S_WB_WAIT);
  assign busy      = (state != S_IDLE);

  assign accept   = req_valid & req_ready;
  assign op_fire  = op_valid & op_ready;
  assign res_fire = res_valid & res_ready;
  assign capture  = (state == S_RD) & tmr_done;

  rf_lat_timer u_lat_timer (
    .CLK      (CLK),
    .CLR      (CLR),
    .load     (accept),
    .load_val (3'(RD_LAT)),
    .en       (state == S_RD),
    .done     (tmr_done)
  );

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:     if (req_valid) state_nxt = S_RD;
      S_RD:       if (tmr_done) state_nxt = S_OP_OUT;
      S_OP_OUT:   if (op_fire) state_nxt = op_we ? S_WB_WAIT : S_IDLE;
      S_WB_WAIT:  if (res_valid) state_nxt = S_WB_WRITE;
      S_WB_WRITE: state_nxt = S_WB_HOLD;
      S_WB_HOLD:  state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs. The OP_OUT entry cycle is a lead-in where op_a/op_b
  // are already captured but op_valid is still low; op_valid rises on the
  // following edge and only falls on a completed handshake.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      SA         <= '0;
      SB         <= '0;
      Mux_EN_Sel <= MUX_EN_OFF;
      op_a       <= '0;
      op_b       <= '0;
      op_rd      <= '0;
      op_we      <= 1'b0;
      op_valid   <= 1'b0;
      DSEL       <= '0;
      IN         <= '0;
      Dec_EN     <= 1'b0;
    end else begin
      if (accept) begin
        SA         <= req_rn;
        SB         <= req_rm;
        op_rd      <= req_rd;
        op_we      <= req_we;
        Mux_EN_Sel <= MUX_EN_BOTH;
      end else if (capture) begin
        op_a       <= PA;
        op_b       <= PB;
        Mux_EN_Sel <= MUX_EN_OFF;
      end

      if (op_fire) begin
        op_valid <= 1'b0;
      end else if (state == S_OP_OUT) begin
        op_valid <= 1'b1;
      end

      // IN/DSEL keep the last written value; only a writeback moves them.
      if (res_fire) begin
        IN   <= res_data;
        DSEL <= op_rd;
      end
      Dec_EN <= res_fire;
    end
  end

endmodule

// File: tb/tb_rf_access_ctrl.sv
module tb_rf_access_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int RD_LAT = 3;

  logic              CLK = 1'b0;
  logic              CLR;
  logic              req_valid, req_ready;
  logic [ADDR_W-1:0] req_rn, req_rm, req_rd;
  logic              req_we;
  logic              op_valid, op_ready;
  logic [DATA_W-1:0] op_a, op_b;
  logic [ADDR_W-1:0] op_rd;
  logic              op_we;
  logic              res_valid, res_ready;
  logic [DATA_W-1:0] res_data;
  logic [ADDR_W-1:0] SA, SB, DSEL;
  logic [1:0]        Mux_EN_Sel;
  logic [DATA_W-1:0] PA, PB, IN;
  logic              Dec_EN, busy;

  rf_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .CLK(CLK), .CLR(CLR),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rn(req_rn), .req_rm(req_rm), .req_rd(req_rd), .req_we(req_we),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .op_rd(op_rd), .op_we(op_we),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .SA(SA), .SB(SB), .Mux_EN_Sel(Mux_EN_Sel), .PA(PA), .PB(PB),
    .DSEL(DSEL), .IN(IN), .Dec_EN(Dec_EN), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Register file attached to the DUT's ports.
  logic [DATA_W-1:0] rf_mem   [16];
  logic [DATA_W-1:0] init_val [16];
  logic [DATA_W-1:0] ref_mem  [16];
  logic              init_phase;
  int                dec_cnt = 0;

  always @(posedge CLK) begin
    if (init_phase) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= init_val[i];
    end else if (Dec_EN) begin
      rf_mem[DSEL] <= IN;
    end
  end

  assign PA = Mux_EN_Sel[0] ? rf_mem[SA] : '0;
  assign PB = Mux_EN_Sel[1] ? rf_mem[SB] : '0;

  always @(negedge CLK) if (Dec_EN) dec_cnt++;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // One transaction; expectations come from ref_mem (transaction-level file
  // model) and the stated latencies. abort_wr pulses CLR while Dec_EN is high.
  task automatic do_txn(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                        input logic we, input logic [31:0] res, input int op_dly,
                        input int res_dly, input logic abort_wr);
    logic [31:0] ea, eb, in_before;
    logic [3:0]  dsel_before;
    int cyc, mux_cnt, dec_before, w;
    ea = ref_mem[rn];
    eb = ref_mem[rm];
    in_before   = IN;
    dsel_before = DSEL;
    dec_before  = dec_cnt;
    req_rn = rn; req_rm = rm; req_rd = rd; req_we = we; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 50) begin tick; w++; end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    tick;
    req_valid = 1'b0;
    req_rn = 4'($urandom); req_rm = 4'($urandom); req_rd = 4'($urandom);
    chk("sa", 32'(SA), 32'(rn));
    chk("sb", 32'(SB), 32'(rm));
    cyc = 0; mux_cnt = 0;
    while (!op_valid && cyc < 50) begin
      if (Mux_EN_Sel == 2'b11) mux_cnt++;
      if (res_ready) chk("res_ready_in_rd", 32'(res_ready), 32'd0);
      tick;
      cyc++;
    end
    chk("op_latency", 32'(cyc), 32'(RD_LAT + 1));
    chk("mux_cycles", 32'(mux_cnt), 32'(RD_LAT));
    chk("mux_off", 32'(Mux_EN_Sel), 32'd0);
    for (int k = 0; k < op_dly; k++) begin
      chk("hold_valid", 32'(op_valid), 32'd1);
      chk("hold_a", op_a, ea);
      chk("hold_b", op_b, eb);
      chk("hold_res_ready", 32'(res_ready), 32'd0);
      tick;
    end
    op_ready = 1'b1;
    chk("op_a", op_a, ea);
    chk("op_b", op_b, eb);
    chk("op_rd", 32'(op_rd), 32'(rd));
    chk("op_we", 32'(op_we), 32'(we));
    tick;
    op_ready = 1'b0;
    chk("op_valid_drop", 32'(op_valid), 32'd0);
    if (we) begin
      for (int k = 0; k < res_dly; k++) begin
        chk("res_ready_wait", 32'(res_ready), 32'd1);
        chk("dec_idle", 32'(Dec_EN), 32'd0);
        tick;
      end
      chk("res_ready", 32'(res_ready), 32'd1);
      res_data = res; res_valid = 1'b1;
      tick;
      res_valid = 1'b0; res_data = $urandom;
      chk("dec_en_hi", 32'(Dec_EN), 32'd1);
      chk("dsel", 32'(DSEL), 32'(rd));
      chk("in", IN, res);
      if (abort_wr) begin
        CLR = 1'b0;
        #1;
        chk("rst_dec_en", 32'(Dec_EN), 32'd0);
        chk("rst_in", IN, 32'd0);
        chk("rst_dsel", 32'(DSEL), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mux", 32'(Mux_EN_Sel), 32'd0);
        tick;
        CLR = 1'b1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_op_valid", 32'(op_valid), 32'd0);
      end else begin
        tick;
        chk("dec_en_lo", 32'(Dec_EN), 32'd0);
        chk("hold_busy", 32'(busy), 32'd1);
        tick;
        chk("wb_idle_busy", 32'(busy), 32'd0);
        chk("wb_idle_ready", 32'(req_ready), 32'd1);
        chk("dec_pulses", 32'(dec_cnt - dec_before), 32'd1);
        ref_mem[rd] = res;
      end
    end else begin
      chk("ro_busy", 32'(busy), 32'd0);
      chk("ro_ready", 32'(req_ready), 32'd1);
      chk("ro_in", IN, in_before);
      chk("ro_dsel", 32'(DSEL), 32'(dsel_before));
      chk("ro_dec_pulses", 32'(dec_cnt - dec_before), 32'd0);
    end
  endtask

  initial begin
    CLR = 1'b0; init_phase = 1'b1;
    req_valid = 1'b0; req_rn = '0; req_rm = '0; req_rd = '0; req_we = 1'b0;
    op_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    for (int i = 0; i < 16; i++) begin
      init_val[i] = $urandom | 32'h1;
      ref_mem[i]  = init_val[i];
    end
    repeat (3) tick;
    init_phase = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_dec_en", 32'(Dec_EN), 32'd0);
    CLR = 1'b1;
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_op_valid", 32'(op_valid), 32'd0);
    chk("reset_in", IN, 32'd0);
    chk("reset_sa", 32'(SA), 32'd0);
    tick;

    // Write R5 then read it back.
    do_txn(4'd0, 4'd1, 4'd5, 1'b1, 32'h0000_0307, 0, 0, 1'b0);
    do_txn(4'd5, 4'd2, 4'd0, 1'b0, 32'h0, 0, 0, 1'b0);
    chk("raw_r5", op_a, 32'h0000_0307);
    // Back-to-back write of R15 then read both ports.
    do_txn(4'd3, 4'd3, 4'd15, 1'b1, 32'hFFFF_FFFF, 0, 0, 1'b0);
    do_txn(4'd15, 4'd15, 4'd1, 1'b0, 32'h0, 0, 0, 1'b0);
    chk("raw_r15_a", op_a, 32'hFFFF_FFFF);
    chk("raw_r15_b", op_b, 32'hFFFF_FFFF);
    // Read-only with op_ready stalled 5 cycles.
    do_txn(4'd4, 4'd11, 4'd7, 1'b0, 32'h0, 5, 0, 1'b0);
    // Reset in the middle of the write pulse; R9 must keep its old value.
    do_txn(4'd2, 4'd3, 4'd9, 1'b1, 32'hDEAD_BEEF, 1, 2, 1'b1);
    do_txn(4'd9, 4'd9, 4'd0, 1'b0, 32'h0, 0, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      do_txn(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
             $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0);
      if ($urandom_range(0, 3) == 0) tick;
    end

    for (int i = 0; i < 16; i++) chk("final_rf", rf_mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
